// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and framing-error detection.
// Optional UART_RX_MAJORITY_EN: each start/data/stop sample is a 2-of-3 vote around the sample point.
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 3_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       uart_rx_in,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       frame_err_out
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sample;

`ifdef UART_RX_MAJORITY_EN
  logic             sync3_q, sync3_d;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  // sync2 is the sample point; sync1 is one cycle newer, sync3 one cycle older,
  // so the vote adds no latency relative to the single-sample build.
  assign sample  = majority3(sync1_q, sync2_q, sync3_q);
  assign sync3_d = sync2_q;
`else
  assign sample  = sync2_q;
`endif

  assign sync1_d = uart_rx_in;
  assign sync2_d = sync1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      WAIT_HIGH: begin
        if (sync2_q) state_d = IDLE;
      end

      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_MID) begin
          if (!sample) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Counter restarts at mid start bit, so every full period lands mid-bit.
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d = {sample, shreg_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      sync3_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`ifdef UART_RX_MAJORITY_EN
      sync3_q <= sync3_d;
`endif
    end
  end

  assign byte_out      = byte_q;
  assign valid_out     = valid_q;
  assign frame_err_out = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level reference model (queue of expected bytes, error count, last good byte)
// checked against pulses captured on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_NS = 330;
  localparam int CLK_NS = 10;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       uart_rx_in;
  logic [7:0] byte_out;
  logic       valid_out;
  logic       frame_err_out;

  always #(CLK_NS / 2) clk_in = ~clk_in;

  uart_rx #(
    .CLOCK_FREQ(100_000_000),
    .BAUD_RATE (3_000_000)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .uart_rx_in   (uart_rx_in),
    .byte_out     (byte_out),
    .valid_out    (valid_out),
    .frame_err_out(frame_err_out)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] got_q[$];
  longint     got_t[$];
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         stab_cnt = 0;
  logic [7:0] prev_byte = 8'h00;

  logic [7:0] exp_q[$];
  int         exp_err = 0;
  logic [7:0] exp_last = 8'h00;

  // Observed events, sampled away from the rising edge.
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      got_q.push_back(byte_out);
      got_t.push_back($time);
    end
    if (frame_err_out === 1'b1) err_cnt++;
    if (valid_out === 1'b1 && frame_err_out === 1'b1) both_cnt++;
    if (rst_in === 1'b1 && valid_out !== 1'b1 && byte_out !== prev_byte) stab_cnt++;
    prev_byte = byte_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int tail_ns);
    uart_rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      #(BIT_NS);
    end
    uart_rx_in = stop_bit;
    #(BIT_NS + tail_ns);
    uart_rx_in = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    drive_frame(b, 1'b1, 0);
    exp_q.push_back(b);
    exp_last = b;
  endtask

  // Each data bit gets a one-cycle inverted spike right on its sampling instant.
  task automatic send_glitched(input logic [7:0] b);
    uart_rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      #155;
      uart_rx_in = ~b[i];
      #10;
      uart_rx_in = b[i];
      #(BIT_NS - 165);
    end
    uart_rx_in = 1'b1;
    #(BIT_NS);
    exp_q.push_back(b);
    exp_last = b;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pulses"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      void'(got_t.pop_front());
    end
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    check({tag, "_ferr_cnt"}, err_cnt, exp_err);
    check({tag, "_byte_out"}, byte_out, exp_last);
  endtask

  logic [7:0] perm[256];
  logic [7:0] tmp;
  longint     t0;
  int         lat;
  int         j;

  initial begin
    rst_in     = 1'b0;
    uart_rx_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_ferr", frame_err_out, 1'b0);
    @(negedge clk_in) #1 rst_in = 1'b1;
    #1000;
    @(posedge clk_in) #1;

    // Every byte value once, shuffled, with short random gaps.
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      t0 = $time;
      send_good(perm[k]);
      lat = (got_t.size() > 0) ? int'((got_t[got_t.size() - 1] - t0) / CLK_NS) : -1;
      n_cmp++;
      assert (lat >= 313 && lat <= 317) else begin
        n_fail++;
        $error("FAIL sweep_latency: observed %0d cycles expected 313..317", lat);
      end
      check_all("sweep");
      #(CLK_NS * $urandom_range(4, 0));
    end

    #1000;
    send_good(8'hA5);
    send_good(8'h3C);
    check_all("back_to_back");

    for (int k = 0; k < 4; k++) send_good(8'($urandom));
    check_all("random_burst");

    #1000;
    drive_frame(8'h55, 1'b0, 1000 - BIT_NS);
    exp_err++;
    check_all("frame_err");
    #1000;
    send_good(8'h81);
    check_all("after_ferr");

    #1000;
    uart_rx_in = 1'b0;
    #50;
    uart_rx_in = 1'b1;
    #1000;
    check_all("start_glitch");
    send_good(8'h7E);
    check_all("after_glitch");

    #1000;
    @(posedge clk_in) #1;
    uart_rx_in = 1'b0;
    #(BIT_NS);
    uart_rx_in = 1'b1;
    #(4 * BIT_NS + 150);
    @(negedge clk_in) #1 rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_byte_out", byte_out, 8'h00);
    check("midrst_valid", valid_out, 1'b0);
    check("midrst_ferr", frame_err_out, 1'b0);
    #1 rst_in = 1'b1;
    exp_last = 8'h00;
    #(5 * BIT_NS);
    check_all("mid_reset");
    #1000;
    @(posedge clk_in) #1;
    send_good(8'h12);
    check_all("after_reset");

`ifdef UART_RX_MAJORITY_EN
    #1000;
    send_glitched(8'hC3);
    check_all("majority");
`endif

    #1000;
    check_all("final");
    check("valid_and_ferr_together", both_cnt, 0);
    check("byte_out_unstable", stab_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
